// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: 8N1 UART command receiver (two bytes, high first) and response transmitter.
// Optional macro BYTE_TIMEOUT_EN drops a stale high byte after TIMEOUT_BITS idle bit-times.
module uart_cmd_responder #(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);
  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;
  localparam logic [0:0] WAIT_HI = 1'b0, WAIT_LO = 1'b1;

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]  rx_st_q, rx_st_d;
  logic [11:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_start, rx_ok, rx_err;
  logic [0:0]  asm_q, asm_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d, cmd_set, timeout;
  logic [1:0]  tx_st_q, tx_st_d;
  logic [11:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d, sent_q, sent_d;

  assign TX        = tx_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign resp_sent = sent_q;

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + 12'd1;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_start = 1'b0;
    rx_ok    = 1'b0;
    rx_err   = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_st_d = S_START;
      end
      S_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_start = !rx_sync_q;
        rx_st_d  = rx_sync_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == BAUD_LAST) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 4'd1;
        rx_st_d  = (rx_bit_q == 4'd7) ? S_STOP : S_DATA;
      end
      default: if (rx_cnt_q == BAUD_LAST) begin
        rx_cnt_d = '0;
        rx_ok    = rx_sync_q;
        rx_err   = !rx_sync_q;
        rx_st_d  = S_IDLE;
      end
    endcase
  end

  // A good low byte publishes {hi,lo}; a framing error or timeout restarts at the high byte.
  always_comb begin
    asm_d   = asm_q;
    hi_d    = hi_q;
    cmd_d   = cmd_q;
    cmd_set = 1'b0;
    if (rx_ok && asm_q == WAIT_HI) begin
      hi_d  = rx_sh_q;
      asm_d = WAIT_LO;
    end else if (rx_ok) begin
      cmd_d   = {hi_q, rx_sh_q};
      cmd_set = 1'b1;
      asm_d   = WAIT_HI;
    end else if (rx_err || timeout) begin
      asm_d = WAIT_HI;
    end
    cmd_rdy_d = cmd_set | (cmd_rdy_q & ~clr_cmd_rdy & ~(rx_start & (asm_q == WAIT_HI)));
  end

`ifdef BYTE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_BITS * BAUD_DIV);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_BITS * BAUD_DIV - 1);
  logic [TO_W-1:0] to_q, to_d;
  assign timeout = (asm_q == WAIT_LO) && !rx_start && (to_q == TO_LAST);
  assign to_d    = ((asm_q == WAIT_LO) && !rx_start && !timeout) ? to_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) to_q <= '0;
    else to_q <= to_d;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q + 12'd1;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    sent_d   = sent_q;
    case (tx_st_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        if (send_resp) begin
          tx_sh_d = resp;
          sent_d  = 1'b0;
          tx_d    = 1'b0;
          tx_st_d = S_START;
        end
      end
      S_START: if (tx_cnt_q == BAUD_LAST) begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_d     = tx_sh_q[0];
        tx_st_d  = S_DATA;
      end
      S_DATA: if (tx_cnt_q == BAUD_LAST) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 4'd1;
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        tx_d     = (tx_bit_q == 4'd7) ? 1'b1 : tx_sh_q[1];
        tx_st_d  = (tx_bit_q == 4'd7) ? S_STOP : S_DATA;
      end
      default: if (tx_cnt_q == BAUD_LAST) begin
        tx_cnt_d = '0;
        sent_d   = 1'b1;
        tx_st_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      asm_q     <= WAIT_HI;
      hi_q      <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      tx_st_q   <= S_IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_q      <= 1'b1;
      sent_q    <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      asm_q     <= asm_d;
      hi_q      <= hi_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_q      <= tx_d;
      sent_q    <= sent_d;
    end
  end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: directed UART stimulus with queue-based scoreboards for commands and TX frames.
module tb_uart_cmd_responder;
  localparam int B = 16;
  logic        clk = 1'b0, rst_n = 1'b1, RX = 1'b1, clr_cmd_rdy = 1'b0, send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, resp_sent;
  logic [15:0] cmd;
  int          checks = 0, errors = 0;
  bit          go = 1'b0;
  logic [15:0] exp_cmd[$];
  logic [7:0]  exp_resp[$];
  logic        rdy_prev = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_responder #(.BAUD_DIV(B), .TIMEOUT_BITS(40)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    RX = v;
    repeat (B) @(negedge clk);
  endtask

  // clr_mode keeps clr_cmd_rdy high through the stop bit until cmd_rdy is seen set
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1, input logic clr_mode = 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    RX = stop;
    for (int i = 0; i < B; i++) begin
      clr_cmd_rdy = clr_mode && !cmd_rdy;
      @(negedge clk);
    end
    clr_cmd_rdy = 1'b0;
    drive_bit(1'b1);
  endtask

  task automatic send_cmd(input logic [15:0] c, input logic clr_mode = 1'b0);
    exp_cmd.push_back(c);
    send_byte(c[15:8]);
    send_byte(c[7:0], 1'b1, clr_mode);
  endtask

  task automatic issue_resp(input logic [7:0] r, input logic expect_it);
    resp = r;
    send_resp = 1'b1;
    if (expect_it) exp_resp.push_back(r);
    @(negedge clk);
    send_resp = 1'b0;
  endtask

  always @(negedge clk) if (go) begin
    if (rst_n && cmd_rdy && !rdy_prev) begin
      if (exp_cmd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd: got %0h expected no command", cmd);
      end else chk("cmd", {16'h0, cmd}, {16'h0, exp_cmd.pop_front()});
    end
    rdy_prev = cmd_rdy;
  end

  initial begin
    logic       tx_prev, ab, unexp;
    logic [7:0] e;
    logic [9:0] fr;
    int         bad;
    wait (go);
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && tx_prev && !TX) begin
        unexp = (exp_resp.size() == 0);
        e = unexp ? 8'h00 : exp_resp.pop_front();
        if (unexp) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_frame: got start bit expected idle line");
        end
        fr = {1'b1, e, 1'b0};
        bad = 0;
        ab = 1'b0;
        for (int n = 0; n < 10 * B; n++) begin
          if (!rst_n) ab = 1'b1;
          if (TX !== fr[n / B] || resp_sent !== 1'b0) bad++;
          @(negedge clk);
        end
        if (!ab && !unexp) begin
          chk("tx_frame_bad_samples", bad, 0);
          chk("resp_sent_end", {31'h0, resp_sent}, 1);
        end
      end
      tx_prev = TX;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e5;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'h0, TX}, 1);
    chk("rst_cmd", {16'h0, cmd}, 0);
    chk("rst_cmd_rdy", {31'h0, cmd_rdy}, 0);
    chk("rst_resp_sent", {31'h0, resp_sent}, 0);
    rst_n = 1'b1;
    go = 1'b1;
    repeat (2 * B) @(negedge clk);
    send_cmd(16'h2F5A);
    chk("t1_rdy", {31'h0, cmd_rdy}, 1);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    chk("t2_clr", {31'h0, cmd_rdy}, 0);
    chk("t2_cmd_hold", {16'h0, cmd}, 32'h2F5A);
    send_cmd(16'h1234, 1'b1);
    chk("t2_set_wins", {31'h0, cmd_rdy}, 1);
    issue_resp(8'hA5, 1'b1);
    repeat (5 * B) @(negedge clk);
    issue_resp(8'h3C, 1'b0);
    repeat (6 * B) @(negedge clk);
    chk("t3_resp_sent_held", {31'h0, resp_sent}, 1);
    issue_resp(8'hC3, 1'b1);
    chk("t3_resp_sent_clr", {31'h0, resp_sent}, 0);
    repeat (11 * B) @(negedge clk);
    send_byte(8'h2F);
    chk("t4_stale_clr", {31'h0, cmd_rdy}, 0);
    send_byte(8'h77, 1'b0);
    chk("t4_frame_rdy", {31'h0, cmd_rdy}, 0);
    chk("t4_frame_cmd", {16'h0, cmd}, 32'h1234);
    send_cmd(16'hABCD);
`ifdef BYTE_TIMEOUT_EN
    e5 = 16'h2233;
`else
    e5 = 16'h1122;
`endif
    send_byte(8'h11);
    repeat (41 * B) @(negedge clk);
    exp_cmd.push_back(e5);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("t5_cmd", {16'h0, cmd}, {16'h0, e5});
    issue_resp(8'h5A, 1'b1);
    fork
      send_byte(8'h77);
      begin
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_tx", {31'h0, TX}, 1);
        chk("t6_cmd_rdy", {31'h0, cmd_rdy}, 0);
        chk("t6_cmd", {16'h0, cmd}, 0);
        chk("t6_resp_sent", {31'h0, resp_sent}, 0);
      end
    join
    rst_n = 1'b1;
    repeat (2 * B) @(negedge clk);
    send_cmd(16'hA500);
    chk("t6_cmd_after", {16'h0, cmd}, 32'hA500);
    for (int i = 0; i < 2000 && (exp_cmd.size() != 0 || exp_resp.size() != 0); i++) @(negedge clk);
    chk("drain_cmd", exp_cmd.size(), 0);
    chk("drain_resp", exp_resp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
